program_loader: RTL and testbench

- Host-side writer for the instruction memory program-load port.
- Receives a byte stream from an external link (UART/SPI front end) over a valid/ready handshake and assembles little-endian 16-bit instructions.
- Drives sequential write strobes, data and addresses into the instruction memory, and holds the CPU core in reset until a complete, checksum-verified image has been written.
- Sits between the serial front end and the fetch-stage instruction memory; its outputs connect directly to the memory's write-enable, instruction-data and instruction-address inputs.

---
 rtl/program_loader_pkg.sv | 18 +
 rtl/program_loader.sv | 132 +++++++++++++
 tb/tb_program_loader.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/program_loader_pkg.sv
// Shared definitions for the program loader: data widths and the loader FSM states.
package program_loader_pkg;

  localparam int HALF_WORD = 16;  // instruction width
  localparam int WORD      = 32;  // address bus width

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA_LO,
    DATA_HI,
    CHECK,
    DONE,
    ERROR
  } loader_state_t;

endpackage : program_loader_pkg

// File: rtl/program_loader.sv
// Program loader: assembles a length-prefixed, XOR-checksummed byte stream into
// 16-bit instructions, writes them into instruction memory, and holds the core
// in reset until a complete and verified image is present.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int MEM_DEPTH      = 512,
  parameter int LOAD_BASE_ADDR = 0
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  input  logic                 start_load_i,
  input  logic                 byte_valid_i,
  input  logic [7:0]           byte_data_i,
  output logic                 byte_ready_o,
  output logic                 program_mem_write_en_o,
  output logic [HALF_WORD-1:0] instruction_o,
  output logic [WORD-1:0]      instruction_addr_o,
  output logic                 core_reset_o,
  output logic                 load_done_o,
  output logic                 load_error_o
);

  localparam int          IDX_W   = $clog2(MEM_DEPTH + 1);
  localparam logic [15:0] MAX_LEN = 16'(MEM_DEPTH);

  loader_state_t        state_q;
  logic [IDX_W-1:0]     index_q;      // halfwords written so far in this load
  logic [15:0]          len_q;        // declared halfword count N
  logic [7:0]           lo_q;         // low byte waiting for its high partner
  logic [7:0]           xor_q;        // running checksum of accepted bytes
  logic                 wr_en_q;
  logic [HALF_WORD-1:0] instr_q;
  logic [WORD-1:0]      addr_q;
  logic                 core_reset_q;
  logic                 done_q;
  logic                 error_q;

  logic        byte_accept;
  logic [15:0] len_d;
  logic        last_half_d;

  // A restart request masks the handshake so the simultaneous byte is dropped.
  assign byte_ready_o = !start_load_i &&
                        (state_q inside {LEN_LO, LEN_HI, DATA_LO, DATA_HI, CHECK});
  assign byte_accept  = byte_valid_i && byte_ready_o;

  // Full length as it will be once the high byte is taken.
  assign len_d       = {byte_data_i, len_q[7:0]};
  // The halfword completing now is the final one of the image.
  assign last_half_d = (16'(index_q) + 16'd1) == len_q;

  // Loader FSM with registered memory-write and status outputs.
  // NOTE: all state here uses non-blocking assignments so every register samples
  // the pre-edge values of its peers; blocking would create order-dependent races.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q      <= IDLE;
      index_q      <= '0;
      len_q        <= '0;
      lo_q         <= '0;
      xor_q        <= '0;
      wr_en_q      <= 1'b0;
      instr_q      <= '0;
      addr_q       <= '0;
      core_reset_q <= 1'b1;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      // The strobe lasts exactly one cycle; a write already on the outputs
      // completes even if a restart arrives in that same cycle.
      wr_en_q <= 1'b0;
      if (start_load_i) begin
        state_q      <= LEN_LO;
        index_q      <= '0;
        xor_q        <= '0;
        core_reset_q <= 1'b1;
        done_q       <= 1'b0;
        error_q      <= 1'b0;
      end else if (byte_accept) begin
        xor_q <= xor_q ^ byte_data_i;
        case (state_q)
          LEN_LO: begin
            len_q[7:0] <= byte_data_i;
            state_q    <= LEN_HI;
          end
          LEN_HI: begin
            len_q[15:8] <= byte_data_i;
            if (len_d > MAX_LEN) begin
              state_q <= ERROR;
              error_q <= 1'b1;
            end else if (len_d == 16'd0) begin
              state_q <= CHECK;
            end else begin
              state_q <= DATA_LO;
            end
          end
          DATA_LO: begin
            lo_q    <= byte_data_i;
            state_q <= DATA_HI;
          end
          DATA_HI: begin
            wr_en_q <= 1'b1;
            instr_q <= {byte_data_i, lo_q};
            addr_q  <= WORD'(LOAD_BASE_ADDR) + WORD'(index_q);
            index_q <= index_q + 1'b1;
            state_q <= last_half_d ? CHECK : DATA_LO;
          end
          CHECK: begin
            if (xor_q == byte_data_i) begin
              state_q      <= DONE;
              done_q       <= 1'b1;
              core_reset_q <= 1'b0;
            end else begin
              state_q <= ERROR;
              error_q <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign program_mem_write_en_o = wr_en_q;
  assign instruction_o          = instr_q;
  assign instruction_addr_o     = addr_q;
  assign core_reset_o           = core_reset_q;
  assign load_done_o            = done_q;
  assign load_error_o           = error_q;

endmodule : program_loader

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: randomized byte streams, a stream-level
// reference model feeding a write scoreboard, and an independent write monitor.
module tb_program_loader;
  import program_loader_pkg::*;

  localparam int MEM_DEPTH = 512;

  logic                 clk_i = 1'b0;
  logic                 reset_n_i = 1'b0;
  logic                 start_load_i = 1'b0;
  logic                 byte_valid_i = 1'b0;
  logic [7:0]           byte_data_i = 8'h00;
  logic                 byte_ready_o;
  logic                 program_mem_write_en_o;
  logic [HALF_WORD-1:0] instruction_o;
  logic [WORD-1:0]      instruction_addr_o;
  logic                 core_reset_o;
  logic                 load_done_o;
  logic                 load_error_o;

  program_loader #(.MEM_DEPTH(MEM_DEPTH), .LOAD_BASE_ADDR(0)) dut (
    .clk_i                  (clk_i),
    .reset_n_i              (reset_n_i),
    .start_load_i           (start_load_i),
    .byte_valid_i           (byte_valid_i),
    .byte_data_i            (byte_data_i),
    .byte_ready_o           (byte_ready_o),
    .program_mem_write_en_o (program_mem_write_en_o),
    .instruction_o          (instruction_o),
    .instruction_addr_o     (instruction_addr_o),
    .core_reset_o           (core_reset_o),
    .load_done_o            (load_done_o),
    .load_error_o           (load_error_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [WORD-1:0]      addr;
    logic [HALF_WORD-1:0] data;
  } wr_t;

  typedef logic [7:0] bytes_t [$];

  wr_t         sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] seen_mem [MEM_DEPTH];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Write monitor: every strobe must match the oldest expected write.
  initial begin
    forever begin
      @(negedge clk_i);
      if (reset_n_i && program_mem_write_en_o) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write at %0t",
                   instruction_addr_o, instruction_o, $time);
        end else begin
          wr_t e;
          e = sb.pop_front();
          check("write_addr", instruction_addr_o, e.addr);
          check("write_data", 32'(instruction_o), 32'(e.data));
          seen_mem[instruction_addr_o[8:0]] = instruction_o;
        end
      end
    end
  end

  // Reference model: parse a whole stream and predict its writes and outcome.
  task automatic model_load(input bytes_t s, output bit exp_done, output bit exp_err);
    int         n;
    logic [7:0] x;
    wr_t        w;
    n = int'({s[1], s[0]});
    exp_done = 1'b0;
    exp_err  = 1'b1;
    if (n > MEM_DEPTH) return;
    x = 8'h00;
    for (int i = 0; i < 2 + 2 * n; i++) x ^= s[i];
    for (int i = 0; i < n; i++) begin
      w.addr = 32'(i);
      w.data = {s[3 + 2 * i], s[2 + 2 * i]};
      sb.push_back(w);
    end
    exp_done = (s[2 + 2 * n] == x);
    exp_err  = !exp_done;
  endtask

  function automatic bytes_t build(input int n, input bit corrupt);
    bytes_t     s;
    logic [7:0] x;
    logic [15:0] nn;
    nn = 16'(n);
    s.push_back(nn[7:0]);
    s.push_back(nn[15:8]);
    for (int i = 0; i < 2 * n; i++) s.push_back(8'($urandom));
    x = 8'h00;
    foreach (s[i]) x ^= s[i];
    if (corrupt) x ^= 8'(1 << $urandom_range(7, 0));
    s.push_back(x);
    return s;
  endfunction

  // Offer one byte after a random idle gap and wait (bounded) for acceptance.
  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int gap;
    int budget;
    bit acc;
    gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
    byte_valid_i = 1'b0;
    repeat (gap) begin
      @(posedge clk_i);
      #1;
    end
    byte_valid_i = 1'b1;
    byte_data_i  = b;
    budget = 20;
    acc = 1'b0;
    while (!acc && budget > 0) begin
      @(negedge clk_i);
      acc = byte_ready_o;
      @(posedge clk_i);
      #1;
      budget--;
    end
    byte_valid_i = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got byte 0x%0h not accepted, expected acceptance within 20 cycles", b);
    end
  endtask

  task automatic start_pulse();
    start_load_i = 1'b1;
    @(posedge clk_i);
    #1;
    start_load_i = 1'b0;
    check("start_done_clr", load_done_o, 0);
    check("start_err_clr", load_error_o, 0);
    check("start_core_reset", core_reset_o, 1);
  endtask

  task automatic run_load(input bytes_t s, input int max_gap);
    bit ed;
    bit ee;
    start_pulse();
    model_load(s, ed, ee);
    foreach (s[i]) send_byte(s[i], max_gap);
    check("load_done", load_done_o, 32'(ed));
    check("load_error", load_error_o, 32'(ee));
    check("core_reset", core_reset_o, 32'(!ed));
    check("ready_after_load", byte_ready_o, 0);
    repeat (2) @(posedge clk_i);
    #1;
    check("writes_drained", sb.size(), 0);
  endtask

  initial begin
    bytes_t s;
    bytes_t s2;
    wr_t    w;

    // Reset state.
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_core_reset", core_reset_o, 1);
    check("rst_wr_en", program_mem_write_en_o, 0);
    check("rst_instr", 32'(instruction_o), 0);
    check("rst_addr", instruction_addr_o, 0);
    check("rst_done", load_done_o, 0);
    check("rst_error", load_error_o, 0);
    reset_n_i = 1'b1;
    @(posedge clk_i);
    #1;
    check("idle_ready", byte_ready_o, 0);

    // Directed good image, then the same image with a bad checksum.
    s = '{8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56, 8'h0A};
    run_load(s, 0);
    s[6] = 8'h0B;
    run_load(s, 0);

    // Oversized length: rejected after the second length byte.
    s = '{8'h01, 8'h02};
    run_load(s, 2);

    // Empty image.
    s = '{8'h00, 8'h00, 8'h00};
    run_load(s, 1);

    // Randomized images with gaps, some with corrupted checksums.
    for (int k = 0; k < 6; k++) begin
      s = build(int'($urandom_range(8, 1)), ($urandom_range(3, 0) == 0));
      run_load(s, 3);
    end

    // Largest legal image, back-to-back bytes.
    s = build(MEM_DEPTH, 1'b0);
    run_load(s, 0);

    // Restart after the first halfword, in the strobe cycle, with a byte offered.
    s = build(3, 1'b0);
    start_pulse();
    w.addr = 32'd0;
    w.data = {s[3], s[2]};
    sb.push_back(w);
    for (int i = 0; i < 4; i++) send_byte(s[i], 2);
    start_load_i = 1'b1;
    byte_valid_i = 1'b1;
    byte_data_i  = 8'hEE;
    @(negedge clk_i);
    check("ready_during_start", byte_ready_o, 0);
    @(posedge clk_i);
    #1;
    start_load_i = 1'b0;
    byte_valid_i = 1'b0;
    check("pending_write_done", sb.size(), 0);
    begin
      bit ed;
      bit ee;
      s2 = build(4, 1'b0);
      model_load(s2, ed, ee);
      foreach (s2[i]) send_byte(s2[i], 2);
      check("restart_done", load_done_o, 32'(ed));
      check("restart_core_reset", core_reset_o, 0);
      repeat (2) @(posedge clk_i);
      #1;
      for (int i = 0; i < 4; i++)
        check("restart_image", 32'(seen_mem[i]), 32'({s2[3 + 2 * i], s2[2 + 2 * i]}));
    end

    // Reset while waiting for a high byte: asynchronous clear, no late strobe.
    s = '{8'h04, 8'h00, 8'hCD, 8'hAB, 8'h11};
    start_pulse();
    w.addr = 32'd0;
    w.data = 16'hABCD;
    sb.push_back(w);
    foreach (s[i]) send_byte(s[i], 1);
    byte_valid_i = 1'b1;
    byte_data_i  = 8'h22;
    #2;
    reset_n_i = 1'b0;
    #1;
    check("arst_core_reset", core_reset_o, 1);
    check("arst_wr_en", program_mem_write_en_o, 0);
    check("arst_instr", 32'(instruction_o), 0);
    check("arst_addr", instruction_addr_o, 0);
    byte_valid_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    reset_n_i = 1'b1;
    repeat (4) @(posedge clk_i);
    #1;
    check("arst_idle_ready", byte_ready_o, 0);
    check("arst_no_pending", sb.size(), 0);
    s = '{8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56, 8'h0A};
    run_load(s, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_program_loader
